nts_rx_dispatch_fifo: RTL and testbench
=======================================

Name: nts_rx_dispatch_fifo

Overview:
- Upstream neighbour of the RX access buffer: captures 64-bit MAC RX frames into one packet store and presents them on the dispatch FIFO interface (packet_available / fifo_empty / rd_en / rd_data).
- Single-packet store: while a packet waits to be drained, further frames are dropped and counted.
- Bad frames (MAC error or overflow) are discarded and are never made visible downstream.

Parameters:
- ADDR_WIDTH, 8, log2 of packet store depth in 64-bit words (256 words = 2048 bytes).

Ports:
- i_clk  in  1  clock.
- i_areset  in  1  reset; synchronous, active-high (name kept per codebase).
- i_clear  in  1  synchronous flush: abort write, release store, empty output.
- i_mac_rx_start  in  1  first word of a frame on this cycle.
- i_mac_rx_data_valid  in  8  byte-valid mask, MSB-first; 0x00 means idle cycle.
- i_mac_rx_data  in  64  frame data, big-endian (byte 0 in bits 63:56).
- i_mac_rx_good  in  1  end of frame, frame OK (pulse, may coincide with the last data word).
- i_mac_rx_bad  in  1  end of frame, frame corrupt (pulse).
- o_dispatch_packet_available  out  1  a committed packet is held.
- o_dispatch_fifo_empty  out  1  no unread word of the committed packet.
- i_dispatch_fifo_rd_en  in  1  pop current word.
- o_dispatch_fifo_rd_data  out  64  current word, first-word-fall-through.
- o_dispatch_bytes  out  ADDR_WIDTH+3  byte length of the committed packet.
- o_drop_count  out  32  frames dropped (busy, bad or overflow), saturating.

Behaviour:
- Reset / i_clear: all outputs 0 except o_dispatch_fifo_empty=1; write FSM goes to IDLE; store is released. i_clear does not reset o_drop_count; i_areset does.
- Write FSM states: IDLE, WRITE, DISCARD.
  - IDLE + start + store free -> WRITE: word 0 written at addr 0, byte count loaded from popcount(data_valid).
  - IDLE + start + store held -> DISCARD.
  - WRITE: each cycle with data_valid!=0 writes the next address; byte count += popcount.
  - WRITE + good -> commit, then IDLE. Commit: packet_available=1 and bytes latched on the next edge.
  - WRITE + bad -> IDLE, no commit, drop_count+1.
  - WRITE + address wraps past 2^ADDR_WIDTH-1 -> DISCARD, drop_count+1.
  - DISCARD + good or bad -> IDLE. drop_count+1 if the frame was not already counted.
  - start while in WRITE or DISCARD: the current frame is treated as bad (drop counted) and the new frame starts.
- Word count = ceil(bytes/8). Data valid bits are not used to mask data; unused bytes are stored as received.
- Read side, FWFT:
  - When packet_available=1, fifo_empty=0 and rd_data=word 0, valid the cycle after commit.
  - rd_en with !empty advances to the next word. The next word appears on rd_data in the following cycle with no bubble, i.e. a registered RAM read with a one-word prefetch register.
  - After the last word is popped, fifo_empty=1 on the next edge while packet_available stays 1.
  - rd_en while empty is ignored.
- Release: packet_available falls one cycle after empty rises and the store becomes free. A start arriving in the same cycle as the release is accepted.
- Simultaneous good and start: end the current frame, then start the new frame (the start is evaluated against the store state after the commit, i.e. dropped).
- Reset or i_clear mid-WRITE: the frame is discarded silently (no drop count); MAC words are ignored until the next start.

Optional Feature:
- Macro NTS_RX_DISPATCH_FIFO_STATS_EN.
- When defined: adds outputs o_stat_accepted (32) and o_stat_bytes (32), both saturating. They count committed packets and the sum of their byte lengths, and are cleared only by i_areset.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package nts_rx_pkg:
  - write FSM state encoding (2 bits);
  - a popcount-of-8 function;
  - the constant WORD_BYTES=8;
  - the drop counter width.
- Sub-module nts_rx_dispatch_ram: simple dual-port, 2^ADDR_WIDTH x 64, registered read. The top level holds both FSMs and the prefetch register.

Test Plan:
- Single frame of 3 words, masks FF,FF,F0 with good on the last word (data deadbeef00000000, abad1deac0fef00d, 0123456789abcdef): packet_available=1 and bytes=20. rd_data reads deadbeef00000000 before any rd_en, then the other two words in order on back-to-back rd_en. fifo_empty=1 after the 3rd pop; packet_available=0 one cycle later.
- Frame ending with bad: no packet_available, drop_count=1, fifo_empty stays 1.
- Second frame arriving while the first is unread: second frame dropped, drop_count increments. After the first is drained, a third frame is accepted with the correct data.
- Frame of 2^ADDR_WIDTH+1 full words: overflow drop, drop_count+1, no commit.
- i_clear asserted mid-read of a 3-word packet: next cycle packet_available=0, empty=1. A new 1-word frame (0x1122334455667788) is then delivered correctly.
- With NTS_RX_DISPATCH_FIFO_STATS_EN: two good frames of 20 and 64 bytes -> o_stat_accepted=2, o_stat_bytes=84.

Source files
------------

// File: rtl/nts_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nts_rx_pkg: shared types and helpers for the RX dispatch FIFO       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package nts_rx_pkg;

  localparam int WORD_BYTES = 8;
  localparam int DROP_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nts_rx_dispatch_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nts_rx_dispatch_ram: simple dual-port packet store, registered read |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module nts_rx_dispatch_ram
  import nts_rx_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     waddr_i,
  input  logic [WORD_BYTES*8-1:0]   wdata_i,
  input  logic [ADDR_WIDTH-1:0]     raddr_i,
  output logic [WORD_BYTES*8-1:0]   rdata_o
);

  localparam int DW = WORD_BYTES * 8;

  logic [DW-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DW-1:0] rdata_q;

  // Write-first on an address collision: the last word of a frame can be
  // committed in the same cycle the read side starts prefetching it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/nts_rx_dispatch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nts_rx_dispatch_fifo: captures MAC RX frames into one packet store  |
// | and presents them as a FWFT dispatch FIFO.                          |
// | Optional counters: NTS_RX_DISPATCH_FIFO_STATS_EN                     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module nts_rx_dispatch_fifo
  import nts_rx_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_areset,
  input  logic                    i_clear,
  input  logic                    i_mac_rx_start,
  input  logic [7:0]              i_mac_rx_data_valid,
  input  logic [63:0]             i_mac_rx_data,
  input  logic                    i_mac_rx_good,
  input  logic                    i_mac_rx_bad,
  output logic                    o_dispatch_packet_available,
  output logic                    o_dispatch_fifo_empty,
  input  logic                    i_dispatch_fifo_rd_en,
  output logic [63:0]             o_dispatch_fifo_rd_data,
  output logic [ADDR_WIDTH+2:0]   o_dispatch_bytes,
`ifdef NTS_RX_DISPATCH_FIFO_STATS_EN
  output logic [31:0]             o_stat_accepted,
  output logic [31:0]             o_stat_bytes,
`endif
  output logic [DROP_CNT_W-1:0]   o_drop_count
);

  localparam int BYTE_SHIFT = $clog2(WORD_BYTES);
  localparam int BCW        = ADDR_WIDTH + BYTE_SHIFT + 1;

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic [BCW-1:0]        wbytes_q, wbytes_d;
  logic                  counted_q, counted_d;

  logic                  drop_inc, commit, start_new, data_ok, overflow;
  logic                  ram_we, head_load;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [63:0]           ram_rdata;
  logic [ADDR_WIDTH:0]   commit_words;
  logic [BCW-1:0]        commit_bytes, pc_ext;

  logic                  avail_q, empty_q;
  logic [ADDR_WIDTH:0]   rd_ptr_q, words_q;
  logic [BCW-2:0]        bytes_q;
  logic [63:0]           head_q;
  logic [DROP_CNT_W-1:0] drop_q;
  logic                  pop, last_pop, release_now, store_free;

  assign pc_ext      = {{(BCW-4){1'b0}}, popcount8(i_mac_rx_data_valid)};
  assign release_now = avail_q && empty_q;
  assign store_free  = !avail_q || release_now;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    wbytes_d     = wbytes_q;
    counted_d    = counted_q;
    drop_inc     = 1'b0;
    commit       = 1'b0;
    start_new    = 1'b0;
    data_ok      = 1'b0;
    overflow     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = wcnt_q[ADDR_WIDTH-1:0];
    head_load    = 1'b0;
    commit_words = wcnt_q;
    commit_bytes = wbytes_q;

    case (state_q)
      ST_IDLE: start_new = i_mac_rx_start;
      ST_WRITE: begin
        if (i_mac_rx_start) begin
          // A coincident good still ends the frame being written
          if (i_mac_rx_good) commit = 1'b1;
          else               drop_inc = 1'b1;
          state_d   = ST_IDLE;
          start_new = 1'b1;
        end else begin
          data_ok  = (i_mac_rx_data_valid != 8'h00);
          overflow = data_ok && wcnt_q[ADDR_WIDTH];
          if (data_ok && !overflow) begin
            ram_we   = 1'b1;
            wcnt_d   = wcnt_q + 1'b1;
            wbytes_d = wbytes_q + pc_ext;
          end
          commit_words = wcnt_d;
          commit_bytes = wbytes_d;
          if (overflow) begin
            drop_inc  = 1'b1;
            counted_d = 1'b1;
            state_d   = (i_mac_rx_good || i_mac_rx_bad) ? ST_IDLE : ST_DISCARD;
          end else if (i_mac_rx_good) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else if (i_mac_rx_bad) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (i_mac_rx_good || i_mac_rx_bad || i_mac_rx_start) begin
          drop_inc = !counted_q;
          state_d  = ST_IDLE;
        end
        start_new = i_mac_rx_start;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_new) begin
      if (store_free && !commit) begin
        ram_we    = 1'b1;
        ram_waddr = '0;
        head_load = 1'b1;
        wcnt_d    = (ADDR_WIDTH+1)'(1);
        wbytes_d  = pc_ext;
        if (state_q == ST_IDLE && i_mac_rx_good) begin
          commit       = 1'b1;
          commit_words = (ADDR_WIDTH+1)'(1);
          commit_bytes = pc_ext;
          state_d      = ST_IDLE;
        end else if (state_q == ST_IDLE && i_mac_rx_bad) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end else if (state_q == ST_IDLE && (i_mac_rx_good || i_mac_rx_bad)) begin
        drop_inc = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        counted_d = 1'b0;
        state_d   = ST_DISCARD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset || i_clear) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      wbytes_q  <= '0;
      counted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wbytes_q  <= wbytes_d;
      counted_q <= counted_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      drop_q <= '0;
    end else if (!i_clear && drop_inc && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  // head_q is the prefetch register (word rd_ptr-1); the RAM output holds word rd_ptr
  assign pop       = i_dispatch_fifo_rd_en && avail_q && !empty_q;
  assign last_pop  = pop && (rd_ptr_q == words_q);
  assign ram_raddr = pop ? (rd_ptr_q[ADDR_WIDTH-1:0] + 1'b1) : rd_ptr_q[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_areset || i_clear) begin
      avail_q  <= 1'b0;
      empty_q  <= 1'b1;
      rd_ptr_q <= (ADDR_WIDTH+1)'(1);
      words_q  <= '0;
      bytes_q  <= '0;
      head_q   <= '0;
    end else begin
      if (commit) begin
        avail_q  <= 1'b1;
        empty_q  <= 1'b0;
        words_q  <= commit_words;
        // A maximum-length frame does not fit the byte output; report all ones
        bytes_q  <= commit_bytes[BCW-1] ? '1 : commit_bytes[BCW-2:0];
        rd_ptr_q <= (ADDR_WIDTH+1)'(1);
      end else if (release_now) begin
        avail_q  <= 1'b0;
        bytes_q  <= '0;
        rd_ptr_q <= (ADDR_WIDTH+1)'(1);
      end else if (pop) begin
        head_q   <= ram_rdata;
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (last_pop) empty_q <= 1'b1;
      end
      if (head_load) head_q <= i_mac_rx_data;
    end
  end

  nts_rx_dispatch_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (i_mac_rx_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef NTS_RX_DISPATCH_FIFO_STATS_EN
  logic [31:0] stat_acc_q, stat_bytes_q;
  logic [32:0] stat_bytes_sum;

  assign stat_bytes_sum = {1'b0, stat_bytes_q} + {{(33-BCW){1'b0}}, commit_bytes};

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      stat_acc_q   <= '0;
      stat_bytes_q <= '0;
    end else if (commit && !i_clear) begin
      if (stat_acc_q != '1) stat_acc_q <= stat_acc_q + 1'b1;
      stat_bytes_q <= stat_bytes_sum[32] ? '1 : stat_bytes_sum[31:0];
    end
  end

  assign o_stat_accepted = stat_acc_q;
  assign o_stat_bytes    = stat_bytes_q;
`endif

  assign o_dispatch_packet_available = avail_q;
  assign o_dispatch_fifo_empty       = empty_q;
  assign o_dispatch_fifo_rd_data     = empty_q ? 64'h0 : head_q;
  assign o_dispatch_bytes            = bytes_q;
  assign o_drop_count                = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_nts_rx_dispatch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nts_rx_dispatch_fifo: directed self-checking bench               |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_nts_rx_dispatch_fifo;

  localparam int ADDR_WIDTH = 8;

  logic                  i_clk = 1'b0;
  logic                  i_areset, i_clear;
  logic                  i_mac_rx_start, i_mac_rx_good, i_mac_rx_bad;
  logic [7:0]            i_mac_rx_data_valid;
  logic [63:0]           i_mac_rx_data;
  logic                  o_dispatch_packet_available, o_dispatch_fifo_empty;
  logic                  i_dispatch_fifo_rd_en;
  logic [63:0]           o_dispatch_fifo_rd_data;
  logic [ADDR_WIDTH+2:0] o_dispatch_bytes;
  logic [31:0]           o_drop_count;
`ifdef NTS_RX_DISPATCH_FIFO_STATS_EN
  logic [31:0]           o_stat_accepted, o_stat_bytes;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  nts_rx_dispatch_fifo #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .i_clk                       (i_clk),
    .i_areset                    (i_areset),
    .i_clear                     (i_clear),
    .i_mac_rx_start              (i_mac_rx_start),
    .i_mac_rx_data_valid         (i_mac_rx_data_valid),
    .i_mac_rx_data               (i_mac_rx_data),
    .i_mac_rx_good               (i_mac_rx_good),
    .i_mac_rx_bad                (i_mac_rx_bad),
    .o_dispatch_packet_available (o_dispatch_packet_available),
    .o_dispatch_fifo_empty       (o_dispatch_fifo_empty),
    .i_dispatch_fifo_rd_en       (i_dispatch_fifo_rd_en),
    .o_dispatch_fifo_rd_data     (o_dispatch_fifo_rd_data),
    .o_dispatch_bytes            (o_dispatch_bytes),
`ifdef NTS_RX_DISPATCH_FIFO_STATS_EN
    .o_stat_accepted             (o_stat_accepted),
    .o_stat_bytes                (o_stat_bytes),
`endif
    .o_drop_count                (o_drop_count)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mac_word(input logic st, input logic [7:0] dv, input logic [63:0] d,
                          input logic g, input logic b);
    i_mac_rx_start      = st;
    i_mac_rx_data_valid = dv;
    i_mac_rx_data       = d;
    i_mac_rx_good       = g;
    i_mac_rx_bad        = b;
    tick();
    i_mac_rx_start      = 1'b0;
    i_mac_rx_data_valid = 8'h00;
    i_mac_rx_good       = 1'b0;
    i_mac_rx_bad        = 1'b0;
  endtask

  task automatic send_20b_frame();
    mac_word(1'b1, 8'hFF, 64'hdeadbeef00000000, 1'b0, 1'b0);
    mac_word(1'b0, 8'hFF, 64'habad1deac0fef00d, 1'b0, 1'b0);
    mac_word(1'b0, 8'hF0, 64'h0123456789abcdef, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    i_areset = 1'b1;
    tick();
    tick();
    i_areset = 1'b0;
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL reset_avail: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b expected 1", o_dispatch_fifo_empty); end
    checks++; if (o_dispatch_fifo_rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", o_dispatch_fifo_rd_data); end
    checks++; if (o_dispatch_bytes !== '0) begin failures++; $display("FAIL reset_bytes: got %0d expected 0", o_dispatch_bytes); end
    checks++; if (o_drop_count !== 32'd0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", o_drop_count); end
  endtask

  task automatic test_single_frame();
    send_20b_frame();
    checks++; if (o_dispatch_packet_available !== 1'b1) begin failures++; $display("FAIL single_avail: got %0b expected 1", o_dispatch_packet_available); end
    checks++; if (o_dispatch_bytes !== 11'd20) begin failures++; $display("FAIL single_bytes: got %0d expected 20", o_dispatch_bytes); end
    checks++; if (o_dispatch_fifo_empty !== 1'b0) begin failures++; $display("FAIL single_empty: got %0b expected 0", o_dispatch_fifo_empty); end
    checks++; if (o_dispatch_fifo_rd_data !== 64'hdeadbeef00000000) begin failures++; $display("FAIL single_word0: got %h expected deadbeef00000000", o_dispatch_fifo_rd_data); end
    i_dispatch_fifo_rd_en = 1'b1;
    tick();
    checks++; if (o_dispatch_fifo_rd_data !== 64'habad1deac0fef00d) begin failures++; $display("FAIL single_word1: got %h expected abad1deac0fef00d", o_dispatch_fifo_rd_data); end
    tick();
    checks++; if (o_dispatch_fifo_rd_data !== 64'h0123456789abcdef) begin failures++; $display("FAIL single_word2: got %h expected 0123456789abcdef", o_dispatch_fifo_rd_data); end
    checks++; if (o_dispatch_fifo_empty !== 1'b0) begin failures++; $display("FAIL single_empty_w2: got %0b expected 0", o_dispatch_fifo_empty); end
    tick();
    i_dispatch_fifo_rd_en = 1'b0;
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL single_empty_end: got %0b expected 1", o_dispatch_fifo_empty); end
    checks++; if (o_dispatch_packet_available !== 1'b1) begin failures++; $display("FAIL single_avail_hold: got %0b expected 1", o_dispatch_packet_available); end
    tick();
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL single_release: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_drop_count !== 32'd0) begin failures++; $display("FAIL single_drop: got %0d expected 0", o_drop_count); end
  endtask

  task automatic test_bad_frame();
    mac_word(1'b1, 8'hFF, 64'h1111111111111111, 1'b0, 1'b0);
    mac_word(1'b0, 8'hFF, 64'h2222222222222222, 1'b0, 1'b1);
    tick();
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL bad_avail: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL bad_empty: got %0b expected 1", o_dispatch_fifo_empty); end
    checks++; if (o_drop_count !== 32'd1) begin failures++; $display("FAIL bad_drop: got %0d expected 1", o_drop_count); end
  endtask

  task automatic test_busy_drop();
    mac_word(1'b1, 8'hFF, 64'hA0A0A0A0A0A0A0A0, 1'b0, 1'b0);
    mac_word(1'b0, 8'hFF, 64'hA1A1A1A1A1A1A1A1, 1'b1, 1'b0);
    mac_word(1'b1, 8'hFF, 64'hB0B0B0B0B0B0B0B0, 1'b0, 1'b0);
    mac_word(1'b0, 8'hFF, 64'hB1B1B1B1B1B1B1B1, 1'b1, 1'b0);
    checks++; if (o_drop_count !== 32'd2) begin failures++; $display("FAIL busy_drop: got %0d expected 2", o_drop_count); end
    checks++; if (o_dispatch_bytes !== 11'd16) begin failures++; $display("FAIL busy_bytes: got %0d expected 16", o_dispatch_bytes); end
    checks++; if (o_dispatch_fifo_rd_data !== 64'hA0A0A0A0A0A0A0A0) begin failures++; $display("FAIL busy_word0: got %h expected a0a0a0a0a0a0a0a0", o_dispatch_fifo_rd_data); end
    i_dispatch_fifo_rd_en = 1'b1;
    tick();
    checks++; if (o_dispatch_fifo_rd_data !== 64'hA1A1A1A1A1A1A1A1) begin failures++; $display("FAIL busy_word1: got %h expected a1a1a1a1a1a1a1a1", o_dispatch_fifo_rd_data); end
    tick();
    i_dispatch_fifo_rd_en = 1'b0;
    // third frame starts in the release cycle
    mac_word(1'b1, 8'hFF, 64'hC0C0C0C0C0C0C0C0, 1'b0, 1'b0);
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL busy_release: got %0b expected 0", o_dispatch_packet_available); end
    mac_word(1'b0, 8'h80, 64'hC1C1C1C1C1C1C1C1, 1'b1, 1'b0);
    checks++; if (o_dispatch_packet_available !== 1'b1) begin failures++; $display("FAIL third_avail: got %0b expected 1", o_dispatch_packet_available); end
    checks++; if (o_dispatch_bytes !== 11'd9) begin failures++; $display("FAIL third_bytes: got %0d expected 9", o_dispatch_bytes); end
    checks++; if (o_dispatch_fifo_rd_data !== 64'hC0C0C0C0C0C0C0C0) begin failures++; $display("FAIL third_word0: got %h expected c0c0c0c0c0c0c0c0", o_dispatch_fifo_rd_data); end
    i_dispatch_fifo_rd_en = 1'b1;
    tick();
    checks++; if (o_dispatch_fifo_rd_data !== 64'hC1C1C1C1C1C1C1C1) begin failures++; $display("FAIL third_word1: got %h expected c1c1c1c1c1c1c1c1", o_dispatch_fifo_rd_data); end
    tick();
    i_dispatch_fifo_rd_en = 1'b0;
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL third_empty: got %0b expected 1", o_dispatch_fifo_empty); end
    tick();
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL third_release: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_drop_count !== 32'd2) begin failures++; $display("FAIL third_drop: got %0d expected 2", o_drop_count); end
  endtask

  task automatic test_overflow();
    mac_word(1'b1, 8'hFF, 64'h0, 1'b0, 1'b0);
    for (int i = 1; i <= (1 << ADDR_WIDTH); i++) begin
      mac_word(1'b0, 8'hFF, 64'(i), 1'b0, 1'b0);
    end
    mac_word(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    tick();
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL ovf_avail: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL ovf_empty: got %0b expected 1", o_dispatch_fifo_empty); end
    checks++; if (o_drop_count !== 32'd3) begin failures++; $display("FAIL ovf_drop: got %0d expected 3", o_drop_count); end
  endtask

  task automatic test_clear();
    // clear mid-write: the tail of that frame must be ignored silently
    mac_word(1'b1, 8'hFF, 64'hEEEEEEEEEEEEEEEE, 1'b0, 1'b0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    mac_word(1'b0, 8'hFF, 64'hEFEFEFEFEFEFEFEF, 1'b1, 1'b0);
    tick();
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL clrw_avail: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_drop_count !== 32'd3) begin failures++; $display("FAIL clrw_drop: got %0d expected 3", o_drop_count); end
    send_20b_frame();
    i_dispatch_fifo_rd_en = 1'b1;
    tick();
    i_dispatch_fifo_rd_en = 1'b0;
    checks++; if (o_dispatch_fifo_rd_data !== 64'habad1deac0fef00d) begin failures++; $display("FAIL clr_word1: got %h expected abad1deac0fef00d", o_dispatch_fifo_rd_data); end
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL clr_avail: got %0b expected 0", o_dispatch_packet_available); end
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL clr_empty: got %0b expected 1", o_dispatch_fifo_empty); end
    checks++; if (o_dispatch_bytes !== '0) begin failures++; $display("FAIL clr_bytes: got %0d expected 0", o_dispatch_bytes); end
    checks++; if (o_drop_count !== 32'd3) begin failures++; $display("FAIL clr_drop: got %0d expected 3", o_drop_count); end
    mac_word(1'b1, 8'hFF, 64'h1122334455667788, 1'b1, 1'b0);
    checks++; if (o_dispatch_packet_available !== 1'b1) begin failures++; $display("FAIL one_avail: got %0b expected 1", o_dispatch_packet_available); end
    checks++; if (o_dispatch_bytes !== 11'd8) begin failures++; $display("FAIL one_bytes: got %0d expected 8", o_dispatch_bytes); end
    checks++; if (o_dispatch_fifo_rd_data !== 64'h1122334455667788) begin failures++; $display("FAIL one_word0: got %h expected 1122334455667788", o_dispatch_fifo_rd_data); end
    i_dispatch_fifo_rd_en = 1'b1;
    tick();
    i_dispatch_fifo_rd_en = 1'b0;
    checks++; if (o_dispatch_fifo_empty !== 1'b1) begin failures++; $display("FAIL one_empty: got %0b expected 1", o_dispatch_fifo_empty); end
    tick();
    checks++; if (o_dispatch_packet_available !== 1'b0) begin failures++; $display("FAIL one_release: got %0b expected 0", o_dispatch_packet_available); end
  endtask

`ifdef NTS_RX_DISPATCH_FIFO_STATS_EN
  task automatic test_stats();
    i_areset = 1'b1;
    tick();
    i_areset = 1'b0;
    checks++; if (o_stat_accepted !== 32'd0) begin failures++; $display("FAIL stat_rst_acc: got %0d expected 0", o_stat_accepted); end
    send_20b_frame();
    i_dispatch_fifo_rd_en = 1'b1;
    repeat (3) tick();
    i_dispatch_fifo_rd_en = 1'b0;
    tick();
    mac_word(1'b1, 8'hFF, 64'h0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      mac_word(1'b0, 8'hFF, 64'(i), (i == 7), 1'b0);
    end
    checks++; if (o_dispatch_bytes !== 11'd64) begin failures++; $display("FAIL stat_frame_bytes: got %0d expected 64", o_dispatch_bytes); end
    checks++; if (o_stat_accepted !== 32'd2) begin failures++; $display("FAIL stat_accepted: got %0d expected 2", o_stat_accepted); end
    checks++; if (o_stat_bytes !== 32'd84) begin failures++; $display("FAIL stat_bytes: got %0d expected 84", o_stat_bytes); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_areset              = 1'b1;
    i_clear               = 1'b0;
    i_mac_rx_start        = 1'b0;
    i_mac_rx_data_valid   = 8'h00;
    i_mac_rx_data         = 64'h0;
    i_mac_rx_good         = 1'b0;
    i_mac_rx_bad          = 1'b0;
    i_dispatch_fifo_rd_en = 1'b0;
    test_reset();
    test_single_frame();
    test_bad_frame();
    test_busy_drop();
    test_overflow();
    test_clear();
`ifdef NTS_RX_DISPATCH_FIFO_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
